imm_extend_pipe: RTL and testbench
==================================

# imm_extend_pipe

Parametrised, pipelined immediate-extension unit for the vector datapath. It takes the raw immediate field and an extension mode from decode. It produces a DATA_W-wide extended scalar and a LANES-wide broadcast vector of that scalar. Results are registered into a 2-entry output buffer with valid/ready handshakes on both sides. It sits between decode and the operand-select stage and also counts illegal extension modes for debug.

## Interface
Parameters:
- IMM_W, 20, width of the raw immediate field (≥16)
- DATA_W, 32, width of the extended scalar (≥IMM_W)
- LANES, 4, number of vector lanes in the broadcast output
- ELEM_W, 8, splat element width; must divide DATA_W
- BR_SHIFT, 2, left shift applied in BRANCH mode

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; one clock; reset is synchronous and active-low
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept a request this cycle
- in_mode  in  3  extension mode (ext_mode_e)
- in_imm  in  IMM_W  raw immediate bits
- in_tag  in  4  opaque tag, returned unchanged with the result
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- out_ext  out  DATA_W  extended scalar
- out_vec  out  LANES*DATA_W  out_ext replicated into every lane (lane 0 in LSBs)
- out_tag  out  4  tag of the current result
- out_illegal  out  1  current result came from an illegal mode
- illegal_cnt  out  8  saturating count of accepted illegal-mode requests

## Operation
- Modes:
  - 0 ZERO: out_ext = zero-extend in_imm[15:0]
  - 1 SIGN: sign-extend in_imm[IMM_W-1:0]
  - 2 BRANCH: sign-extend in_imm to DATA_W, shift left by BR_SHIFT, truncate to DATA_W
  - 3 SPLAT: replicate in_imm[ELEM_W-1:0] DATA_W/ELEM_W times
  - 4 UPPER: {in_imm[15:0], zeros} in the top 16 bits
  - 5–7 ILLEGAL: out_ext = 0, out_illegal = 1
- Extension is combinational on the input side. The result, tag and illegal flag are written into the buffer on acceptance (in_valid && in_ready).
- Buffer: 2-entry FIFO with count 0..2. Ordering is strict FIFO.
- in_ready = (count != 2). It is derived only from registered state and has no combinational path from out_ready.
- out_valid = (count != 0). The out_* fields always show the head entry.
- Pop when out_valid && out_ready. Push and pop in the same cycle leave count unchanged, and both take effect.
- illegal_cnt increments once per accepted illegal request and saturates at 255.
- out_* data fields are undefined-free: when out_valid=0 they hold 0.

## Timing
- Latency: a request accepted at edge N is visible on out_* with out_valid=1 after edge N. That is one cycle when the buffer is empty.
- Throughput: one result per cycle when out_ready is held high.
- Reset (rst_n low at an edge): count=0, buffer contents=0, illegal_cnt=0. Outputs become out_valid=0, in_ready=1, out_ext=0, out_vec=0, out_tag=0, out_illegal=0.
- Reset mid-operation discards all buffered results with no partial output. in_ready is 1 in the first cycle after reset.
- With count=2, a push is impossible because in_ready=0. A pop frees a slot, and in_ready rises in the next cycle.
- With count=0 and in_valid=1, there is no bypass: out_valid rises only after the edge.
- Once out_valid=1, the out_* fields are held stable until popped.

## Structure
- Package imm_ext_pkg holds:
  - ext_mode_e, a 3-bit enum ZERO/SIGN/BRANCH/SPLAT/UPPER
  - a packed struct ext_entry_t holding ext, tag and illegal
  - the constant TAG_W=4
- Sub-module imm_ext_fifo2 is a generic 2-entry FIFO of ext_entry_t with count, push, pop, full and empty.
- Top level holds:
  - the combinational extension function
  - lane replication
  - the saturating counter

## Test plan
- Each legal mode, with defaults and out_ready=1:
  - ZERO 0xF1234 → 0x00001234
  - SIGN 0x80001 → 0xFFF80001
  - BRANCH 0xFFFFF → 0xFFFFFFFC
  - SPLAT 0x000A5 → 0xA5A5A5A5 with out_vec = 4×0xA5A5A5A5
  - UPPER 0x0ABCD → 0xABCD0000
  - each result appears one cycle after acceptance, with the tag echoed
- Backpressure: hold out_ready=0 and drive tags 1, 2, 3.
  - in_ready drops after two acceptances and tag 3 stalls.
  - Raise out_ready: results come out in order 1, 2, 3, with in_ready back to 1 one cycle after the first pop.
- Streaming: 16 back-to-back requests with out_ready=1 give 16 results on consecutive cycles and count never exceeds 1.
- Illegal mode: mode=6 with imm 0x12345 gives out_ext=0 and out_illegal=1, and illegal_cnt increments by 1.
  - 300 illegal requests leave illegal_cnt=255.
- Reset mid-operation: buffer holds 2 entries, then rst_n=0 for one edge.
  - Next cycle: out_valid=0, in_ready=1, illegal_cnt=0, and no stale result ever appears.
- Simultaneous push and pop at count=1 keep count=1, and the new entry follows the popped one.

Source files
------------

// File: rtl/imm_ext_pkg.sv
// Shared types for the immediate-extension pipeline.
package imm_ext_pkg;

  localparam int TAG_W      = 4;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [2:0] {
    ZERO   = 3'd0,
    SIGN   = 3'd1,
    BRANCH = 3'd2,
    SPLAT  = 3'd3,
    UPPER  = 3'd4
  } ext_mode_e;

  typedef struct packed {
    logic [DEF_DATA_W-1:0] ext;
    logic [TAG_W-1:0]      tag;
    logic                  illegal;
  } ext_entry_t;

endpackage

// File: rtl/imm_extend_pipe_if.sv
// Decode-side request and operand-select-side result bundle of the extension unit.
interface imm_extend_pipe_if #(
  parameter int IMM_W  = 20,
  parameter int DATA_W = 32,
  parameter int LANES  = 4
);
  import imm_ext_pkg::*;

  logic                    in_valid;
  logic                    in_ready;
  logic [2:0]              in_mode;
  logic [IMM_W-1:0]        in_imm;
  logic [TAG_W-1:0]        in_tag;
  logic                    out_valid;
  logic                    out_ready;
  logic [DATA_W-1:0]       out_ext;
  logic [LANES*DATA_W-1:0] out_vec;
  logic [TAG_W-1:0]        out_tag;
  logic                    out_illegal;
  logic [7:0]              illegal_cnt;

  modport master (
    output in_valid, in_mode, in_imm, in_tag, out_ready,
    input  in_ready, out_valid, out_ext, out_vec, out_tag, out_illegal, illegal_cnt
  );

  modport slave (
    input  in_valid, in_mode, in_imm, in_tag, out_ready,
    output in_ready, out_valid, out_ext, out_vec, out_tag, out_illegal, illegal_cnt
  );

endinterface

// File: rtl/imm_extend_pipe_fifo2.sv
// Two-entry FIFO; pushes while full and pops while empty are ignored.
module imm_ext_fifo2
  import imm_ext_pkg::*;
#(
  parameter type T = ext_entry_t
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_push,
  input  T           i_data,
  input  logic       i_pop,
  output T           o_head,
  output logic [1:0] o_count,
  output logic       o_full,
  output logic       o_empty
);

  T           r_mem [2];
  logic       r_wr_ptr;
  logic       r_rd_ptr;
  logic [1:0] r_count;
  logic       w_push_ok;
  logic       w_pop_ok;

  assign o_full    = (r_count == 2'd2);
  assign o_empty   = (r_count == 2'd0);
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;
  assign o_head    = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop_ok) r_rd_ptr <= ~r_rd_ptr;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// Immediate extension with lane broadcast, buffered behind a 2-entry result FIFO.
module imm_extend_pipe
  import imm_ext_pkg::*;
#(
  parameter int IMM_W    = 20,
  parameter int DATA_W   = 32,
  parameter int LANES    = 4,
  parameter int ELEM_W   = 8,
  parameter int BR_SHIFT = 2
) (
  input logic              clk,
  input logic              rst_n,
  imm_extend_pipe_if.slave bus
);

  typedef struct packed {
    logic [DATA_W-1:0] ext;
    logic [TAG_W-1:0]  tag;
    logic              illegal;
  } entry_t;

  logic signed [DATA_W-1:0] w_sx;
  logic [DATA_W-1:0]        w_ext;
  logic                     w_illegal;
  logic                     w_push;
  logic                     w_pop;
  entry_t                   w_new;
  entry_t                   w_head;
  logic [1:0]               w_count;
  logic                     w_full;
  logic                     w_empty;
  logic [7:0]               r_illegal_cnt;

  assign w_sx = DATA_W'($signed(bus.in_imm));

  always_comb begin
    w_ext     = '0;
    w_illegal = 1'b0;
    case (bus.in_mode)
      ZERO:    w_ext = DATA_W'(bus.in_imm[15:0]);
      SIGN:    w_ext = w_sx;
      BRANCH:  w_ext = w_sx << BR_SHIFT;
      SPLAT:   w_ext = {(DATA_W/ELEM_W){bus.in_imm[ELEM_W-1:0]}};
      UPPER:   w_ext = DATA_W'(bus.in_imm[15:0]) << (DATA_W-16);
      default: w_illegal = 1'b1;
    endcase
  end

  assign w_new = '{ext: w_ext, tag: bus.in_tag, illegal: w_illegal};

  // in_ready depends only on the registered fill level, never on out_ready
  assign bus.in_ready  = !w_full;
  assign bus.out_valid = (w_count != 2'd0);
  assign w_push        = bus.in_valid && bus.in_ready;
  assign w_pop         = bus.out_valid && bus.out_ready;

  imm_ext_fifo2 #(.T(entry_t)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (w_new),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign bus.out_ext     = w_empty ? '0 : w_head.ext;
  assign bus.out_tag     = w_empty ? '0 : w_head.tag;
  assign bus.out_illegal = w_empty ? 1'b0 : w_head.illegal;
  assign bus.out_vec     = {LANES{bus.out_ext}};
  assign bus.illegal_cnt = r_illegal_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_illegal_cnt <= 8'd0;
    end else if (w_push && w_illegal && (r_illegal_cnt != 8'hFF)) begin
      r_illegal_cnt <= r_illegal_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Randomized and directed bench for imm_extend_pipe against a queue-based reference model.
module tb_imm_extend_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  imm_extend_pipe_if #(.IMM_W(20), .DATA_W(32), .LANES(4)) ifc ();

  imm_extend_pipe #(
    .IMM_W(20), .DATA_W(32), .LANES(4), .ELEM_W(8), .BR_SHIFT(2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  typedef struct {
    logic [31:0] ext;
    logic [3:0]  tag;
    bit          ill;
  } ent_t;

  ent_t q[$];
  int   m_cnt = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference extension from the mode rules, using plain integer arithmetic
  function automatic logic [31:0] ref_ext(input int mode, input int unsigned imm, output bit ill);
    longint s;
    ill = 1'b0;
    s = ((imm & 32'hFFFFF) >= 32'h80000) ? longint'(imm & 32'hFFFFF) - 64'sd1048576
                                         : longint'(imm & 32'hFFFFF);
    case (mode)
      0: return imm & 32'hFFFF;
      1: return 32'(s);
      2: return 32'(s * 4);
      3: return (imm & 32'hFF) * 32'h01010101;
      4: return (imm & 32'hFFFF) * 32'd65536;
      default: begin ill = 1'b1; return 32'd0; end
    endcase
  endfunction

  task automatic check_outputs();
    logic [31:0] e_ext;
    logic [3:0]  e_tag;
    bit          e_ill;
    e_ext = 32'd0; e_tag = 4'd0; e_ill = 1'b0;
    if (q.size() > 0) begin
      e_ext = q[0].ext; e_tag = q[0].tag; e_ill = q[0].ill;
    end
    chk("in_ready",    128'(ifc.in_ready),    128'(q.size() != 2));
    chk("out_valid",   128'(ifc.out_valid),   128'(q.size() != 0));
    chk("out_ext",     128'(ifc.out_ext),     128'(e_ext));
    chk("out_vec",     128'(ifc.out_vec),     {e_ext, e_ext, e_ext, e_ext});
    chk("out_tag",     128'(ifc.out_tag),     128'(e_tag));
    chk("out_illegal", 128'(ifc.out_illegal), 128'(e_ill));
    chk("illegal_cnt", 128'(ifc.illegal_cnt), 128'(m_cnt));
  endtask

  // One cycle: drive after the edge, check at negedge, advance the model, return at edge+1
  task automatic step(input bit v, input logic [2:0] m, input logic [19:0] imm,
                      input logic [3:0] tg, input bit ordy, input bit rst_lo);
    bit   acc, pp, ill;
    ent_t e;
    ifc.in_valid  = v;
    ifc.in_mode   = m;
    ifc.in_imm    = imm;
    ifc.in_tag    = tg;
    ifc.out_ready = ordy;
    rst_n         = !rst_lo;
    @(negedge clk);
    check_outputs();
    if (rst_lo) begin
      q.delete();
      m_cnt = 0;
    end else begin
      acc = v && (q.size() < 2);
      pp  = ordy && (q.size() > 0);
      if (pp) void'(q.pop_front());
      if (acc) begin
        e.ext = ref_ext(int'(m), 32'(imm), ill);
        e.tag = tg;
        e.ill = ill;
        q.push_back(e);
        if (ill && m_cnt < 255) m_cnt++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  int unsigned dir_imm [5] = '{32'hF1234, 32'h80001, 32'hFFFFF, 32'h000A5, 32'h0ABCD};
  logic [31:0] dir_exp [5] = '{32'h00001234, 32'hFFF80001, 32'hFFFFFFFC, 32'hA5A5A5A5, 32'hABCD0000};

  initial begin
    ifc.in_valid = 1'b0; ifc.in_mode = 3'd0; ifc.in_imm = '0; ifc.in_tag = '0;
    ifc.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_out_valid", 128'(ifc.out_valid), 128'(0));
    chk("rst_in_ready",  128'(ifc.in_ready),  128'(1));
    chk("rst_out_ext",   128'(ifc.out_ext),   128'(0));
    chk("rst_out_vec",   128'(ifc.out_vec),   128'(0));
    chk("rst_cnt",       128'(ifc.illegal_cnt), 128'(0));

    // Each legal mode, visible one cycle after acceptance
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 3'(i), 20'(dir_imm[i]), 4'(i + 5), 1'b1, 1'b0);
      chk("mode_valid", 128'(ifc.out_valid), 128'(1));
      chk("mode_ext",   128'(ifc.out_ext),   128'(dir_exp[i]));
      chk("mode_tag",   128'(ifc.out_tag),   128'(i + 5));
      if (i == 3) chk("splat_vec", 128'(ifc.out_vec), {4{32'hA5A5A5A5}});
      step(1'b0, 3'd0, 20'd0, 4'd0, 1'b1, 1'b0);
    end

    // Backpressure with tags 1, 2, 3
    step(1'b1, 3'd1, 20'h00111, 4'd1, 1'b0, 1'b0);
    step(1'b1, 3'd1, 20'h00222, 4'd2, 1'b0, 1'b0);
    chk("bp_full", 128'(ifc.in_ready), 128'(0));
    step(1'b1, 3'd1, 20'h00333, 4'd3, 1'b0, 1'b0);
    step(1'b1, 3'd1, 20'h00333, 4'd3, 1'b1, 1'b0);
    chk("bp_ready_back", 128'(ifc.in_ready), 128'(1));
    chk("bp_order2",     128'(ifc.out_tag),  128'(2));
    step(1'b1, 3'd1, 20'h00333, 4'd3, 1'b1, 1'b0);
    chk("bp_order3",     128'(ifc.out_tag),  128'(3));
    step(1'b0, 3'd0, 20'd0, 4'd0, 1'b1, 1'b0);
    step(1'b0, 3'd0, 20'd0, 4'd0, 1'b1, 1'b0);

    // Streaming back-to-back
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 3'($urandom_range(0, 4)), 20'($urandom), 4'(i), 1'b1, 1'b0);
      chk("stream_valid", 128'(ifc.out_valid), 128'(1));
      chk("stream_tag",   128'(ifc.out_tag),   128'(i));
      chk("stream_ready", 128'(ifc.in_ready),  128'(1));
    end
    step(1'b0, 3'd0, 20'd0, 4'd0, 1'b1, 1'b0);

    // Illegal mode and saturation
    step(1'b1, 3'd6, 20'h12345, 4'd9, 1'b1, 1'b0);
    chk("ill_ext",  128'(ifc.out_ext),     128'(0));
    chk("ill_flag", 128'(ifc.out_illegal), 128'(1));
    chk("ill_cnt",  128'(ifc.illegal_cnt), 128'(1));
    for (int i = 0; i < 300; i++)
      step(1'b1, 3'($urandom_range(5, 7)), 20'($urandom), 4'(i), 1'b1, 1'b0);
    step(1'b0, 3'd0, 20'd0, 4'd0, 1'b1, 1'b0);
    chk("ill_sat", 128'(ifc.illegal_cnt), 128'(255));

    // Simultaneous push and pop at one entry
    step(1'b1, 3'd0, 20'h0AAAA, 4'd10, 1'b0, 1'b0);
    step(1'b1, 3'd0, 20'h0BBBB, 4'd11, 1'b1, 1'b0);
    chk("pp_valid", 128'(ifc.out_valid), 128'(1));
    chk("pp_ready", 128'(ifc.in_ready),  128'(1));
    chk("pp_tag",   128'(ifc.out_tag),   128'(11));
    chk("pp_ext",   128'(ifc.out_ext),   128'(32'h0000BBBB));
    step(1'b0, 3'd0, 20'd0, 4'd0, 1'b1, 1'b0);

    // Reset with two buffered entries
    step(1'b1, 3'd1, 20'h00001, 4'd12, 1'b0, 1'b0);
    step(1'b1, 3'd1, 20'h00002, 4'd13, 1'b0, 1'b0);
    step(1'b0, 3'd0, 20'd0, 4'd0, 1'b0, 1'b1);
    chk("mrst_valid", 128'(ifc.out_valid),   128'(0));
    chk("mrst_ready", 128'(ifc.in_ready),    128'(1));
    chk("mrst_cnt",   128'(ifc.illegal_cnt), 128'(0));
    repeat (3) step(1'b0, 3'd0, 20'd0, 4'd0, 1'b1, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 600; i++)
      step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 20'($urandom),
           4'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 99) == 0));
    repeat (3) step(1'b0, 3'd0, 20'd0, 4'd0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
